// File: rtl/dconv_k1_feeder.sv
// dconv_k1_feeder
// ---------------------------------------------------------------------------
// Transmit side of the depthwise 1x1 conv input stream. One accepted start
// streams an INPUT_SIZE x INPUT_SIZE feature map, with all channels packed
// into each word, out of a synchronous-read buffer as input_vld/input_din
// beats. The per-channel weight/bias/shift words are held stable for the
// whole frame.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               frame request, accepted only while idle
//   stall               suppresses new read issue while high
//   cfg_wr, cfg_*       config load into the holding registers (idle only)
//   mem_rd_en/mem_addr  registered buffer read strobe and address
//   mem_rd_data         buffer data, valid the cycle after mem_rd_en
//   input_vld/din       stream beat valid / data (din is mem_rd_data)
//   weight/bias/shift_din  held configuration
//   busy                high from the first read cycle through the done cycle
//   done                one-cycle pulse at frame end
//   cksum               (DCONV_FEEDER_CKSUM_EN only) XOR of all beats of the
//                       current/last frame
//
// Optional feature: define DCONV_FEEDER_CKSUM_EN to add the cksum port.
// ---------------------------------------------------------------------------
module dconv_k1_feeder #(
  parameter int N             = 8,
  parameter int INPUT_CHANNEL = 3,
  parameter int INPUT_SIZE    = 6,
  parameter int ADDR_W        = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          cfg_wr,
  input  logic [INPUT_CHANNEL*N-1:0]    cfg_weight,
  input  logic [INPUT_CHANNEL*32-1:0]   cfg_bias,
  input  logic [INPUT_CHANNEL*5-1:0]    cfg_shift,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [INPUT_CHANNEL*N-1:0]    mem_rd_data,
  output logic                          input_vld,
  output logic [INPUT_CHANNEL*N-1:0]    input_din,
  output logic [INPUT_CHANNEL*N-1:0]    weight_din,
  output logic [INPUT_CHANNEL*32-1:0]   bias_din,
  output logic [INPUT_CHANNEL*5-1:0]    shift_din,
  output logic                          busy,
  output logic                          done
`ifdef DCONV_FEEDER_CKSUM_EN
  ,
  output logic [INPUT_CHANNEL*N-1:0]    cksum
`endif
);

  localparam int FRAME = INPUT_SIZE * INPUT_SIZE;
  // One extra bit so the issue counter can hold FRAME itself ("all issued").
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FRAME_C = CNT_W'(FRAME);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;     // number of addresses issued so far
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                vld_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [INPUT_CHANNEL*N-1:0]  weight_q;
  logic [INPUT_CHANNEL*32-1:0] bias_q;
  logic [INPUT_CHANNEL*5-1:0]  shift_q;

  // Read strobe/address are registered, so the issue decision for a cycle is
  // made on the edge that enters it. That is why the start-accept edge
  // already issues address 0: the first READ cycle carries the first read.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
          if (!stall) begin
            rd_en_d = 1'b1;
            addr_d  = '0;
            cnt_d   = ONE_C;
          end
        end
      end
      S_READ: begin
        // The cycle holding the final read is still READ; the next is DRAIN.
        if (cnt_q == FRAME_C) begin
          state_d = S_DRAIN;
        end else if (!stall) begin
          rd_en_d = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          cnt_d   = cnt_q + ONE_C;
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      vld_q   <= rd_en_q;   // beat lines up with the RAM's one-cycle latency
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Config holding registers only load while idle so a frame always sees one
  // consistent set of weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      bias_q   <= '0;
      shift_q  <= '0;
    end else if (state_q == S_IDLE && cfg_wr) begin
      weight_q <= cfg_weight;
      bias_q   <= cfg_bias;
      shift_q  <= cfg_shift;
    end
  end

`ifdef DCONV_FEEDER_CKSUM_EN
  logic [INPUT_CHANNEL*N-1:0] cksum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cksum_q <= '0;
    end else if (vld_q) begin
      cksum_q <= cksum_q ^ mem_rd_data;
    end
  end

  assign cksum = cksum_q;
`endif

  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign input_vld  = vld_q;
  assign input_din  = mem_rd_data;
  assign weight_din = weight_q;
  assign bias_din   = bias_q;
  assign shift_din  = shift_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
